uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

Synthesizable UART transmitter that consumes byte writes from the CSR unit's `muarttx` (0x7c0) path and drives a serial 8N1 line. It replaces the simulation-only character sink with real hardware. A small FIFO decouples the core from line rate. The block also exports the TX status bits read through `muartstat` (0xfc0).

## Interface
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, default 8: TX FIFO entries; must be a power of 2, ≥ 2.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `tx_valid`  in  1  CSR unit presents a byte (write to `muarttx`).
- `tx_data`  in  8  byte to send.
- `tx_ready`  out  1  FIFO can accept a byte; a push occurs iff `tx_valid & tx_ready` at a rising edge.
- `stat_txfull`  out  1  FIFO holds `FIFO_DEPTH` entries (`muartstat` bit 0).
- `stat_txidle`  out  1  FSM in IDLE and FIFO empty (`muartstat` bit 1).
- `stat_txcount`  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- `uart_txd`  out  1  serial line, registered; idles high.

## Operation
- Reset (`rst`=0 at an edge):
  - FIFO pointers and count become 0; FSM enters IDLE; baud and bit counters become 0.
  - Output values: `uart_txd`=1, `tx_ready`=1, `stat_txfull`=0, `stat_txidle`=1, `stat_txcount`=0.
  - Reset has priority over all other events, including a frame in progress. A partially sent frame is abandoned and the line returns high the next cycle.
- FIFO and `tx_ready`:
  - `tx_ready` = ~`stat_txfull`, decoded from the registered count.
  - A push attempted when full is dropped. The CSR unit must stall; the block does not.
  - Simultaneous push and pop leave the count unchanged.
  - When full, a push in the same cycle as a pop is still refused.
  - Pointers wrap modulo `FIFO_DEPTH`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `uart_txd`=1. If FIFO non-empty: pop the head into the shift register, go to START.
  - START: `uart_txd`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `uart_txd`=shift[0], LSB first. Shift right every `CLKS_PER_BIT` cycles. After bit index 7 completes, go to STOP.
  - STOP: `uart_txd`=1 for `CLKS_PER_BIT` cycles. On the last cycle of STOP:
    - if the FIFO is non-empty, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Baud counter: counts 0..`CLKS_PER_BIT`-1 and resets to 0 on every state change. Its width is clog2(`CLKS_PER_BIT`).
- Bit index: 3 bits, used only in DATA.

## Timing
- A push at edge N into an empty FIFO with the FSM in IDLE:
  - edge N+1 pops the byte and `uart_txd` falls;
  - the start bit occupies cycles N+1 .. N+`CLKS_PER_BIT`.
- One frame = 10×`CLKS_PER_BIT` cycles. Back-to-back frames have no gap.
- `stat_*` outputs reflect registered state. They update one edge after the causing push or pop.
- `stat_txidle` returns to 1 on the edge that ends the final STOP with the FIFO empty.
- `uart_txd` is glitch-free: it is driven directly from a flop.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (2-bit IDLE/START/DATA/STOP);
  - CSR address constants `CSR_MUARTTX`=12'h7c0, `CSR_MUARTSTAT`=12'hfc0, `CSR_MUARTRX`=12'hfc1;
  - `muartstat` bit positions.
- One sub-module: `sync_fifo` (parameterised width/depth; push/pop/count/full/empty, synchronous active-low `rst`). A future RX block reuses it.
- Top module holds the FSM, baud counter, shift register and status logic.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=8.
- Reset: hold `rst`=0 for 3 cycles -> `uart_txd`=1, `tx_ready`=1, `stat_txcount`=0, `stat_txidle`=1.
- Single byte: push 0x55 at edge N -> `uart_txd` 0 for cycles N+1..N+4, then data bits 1,0,1,0,1,0,1,0 (4 cycles each), then stop 1 for 4 cycles. `stat_txidle`=1 at N+41.
- Back-to-back: push 0xA5 then 0x3C on consecutive cycles -> two 40-cycle frames. The 0x3C start bit begins on the cycle immediately after the 0xA5 stop bit ends.
- Overflow: push 0x00..0x09 on 10 consecutive edges:
  - 0x00 is popped at edge 1 and the count reaches 8 after edge 8;
  - 0x09 is refused (`tx_ready`=0);
  - the line carries 0x00..0x08 in 9 gapless frames (360 cycles).
- Full with simultaneous pop: with count=8, assert `tx_valid` on the cycle the FSM pops at a STOP→START transition -> push refused and count becomes 7.
- Reset mid-frame: assert `rst`=0 during DATA bit 3 with 2 bytes queued -> next cycle `uart_txd`=1 and count=0. After release, the line stays high with no residual frames.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, CSR addresses and status bit positions
package uart_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} tx_state_e;
    localparam logic [11:0] CSR_MUARTTX   = 12'h7c0;
    localparam logic [11:0] CSR_MUARTSTAT = 12'hfc0;
    localparam logic [11:0] CSR_MUARTRX   = 12'hfc1;
    localparam int STAT_TXFULL_BIT = 0;
    localparam int STAT_TXIDLE_BIT = 1;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; pushes when full and pops when empty are ignored
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    logic do_push, do_pop;
    assign full_o  = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign data_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: FIFO-buffered 8N1 UART transmitter with muartstat status outputs
module uart_tx_ctrl import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_valid,
    input  logic [7:0]                    tx_data,
    output logic                          tx_ready,
    output logic                          stat_txfull,
    output logic                          stat_txidle,
    output logic [$clog2(FIFO_DEPTH):0]   stat_txcount,
    output logic                          uart_txd
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    tx_state_e state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic txd_q, txd_d;
    logic pop, empty, full, baud_last;
    logic [7:0] head;
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_valid),
        .data_i  (tx_data),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (stat_txcount)
    );
    assign tx_ready    = ~full;
    assign stat_txfull = full;
    assign stat_txidle = (state_q == IDLE) & empty;
    assign uart_txd    = txd_q;
    assign baud_last   = baud_q == BW'(CLKS_PER_BIT - 1);
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                shift_d = head;
                state_d = START;
            end
            START: if (baud_last) begin
                bit_d   = 3'd0;
                state_d = DATA;
            end
            DATA: if (baud_last) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 3'd1;
                state_d = (bit_q == 3'd7) ? STOP : DATA;
            end
            default: if (baud_last) begin
                // chain straight into the next start bit so queued bytes leave gapless
                pop     = ~empty;
                shift_d = empty ? shift_q : head;
                state_d = empty ? IDLE : START;
            end
        endcase
        baud_d = (state_q == IDLE || baud_last || state_d != state_q) ? '0 : baud_q + BW'(1);
        txd_d  = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed self-checking bench for uart_tx_ctrl at 4 clocks/bit, 8-deep FIFO
module tb_uart_tx_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic tx_ready, stat_txfull, stat_txidle, uart_txd;
    logic [3:0] stat_txcount;
    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int n, m;
    logic txlog [0:4095];
    uart_tx_ctrl #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .stat_txfull  (stat_txfull),
        .stat_txidle  (stat_txidle),
        .stat_txcount (stat_txcount),
        .uart_txd     (uart_txd)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < 4096) txlog[cyc] = uart_txd;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic step(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask
    function automatic logic [39:0] frame_exp(input logic [7:0] b);
        logic [39:0] f;
        for (int i = 0; i < 40; i++) f[i] = (i < 4) ? 1'b0 : (i < 36) ? b[(i - 4) / 4] : 1'b1;
        return f;
    endfunction
    task automatic chk_frame(input string tag, input int s, input logic [7:0] b);
        logic [39:0] got;
        for (int i = 0; i < 40; i++) got[i] = txlog[s + i];
        chk(tag, 64'(got), 64'(frame_exp(b)));
    endtask
    initial begin
        step(3);
        chk("rst_txd", 64'(uart_txd), 64'd1);
        chk("rst_ready", 64'(tx_ready), 64'd1);
        chk("rst_count", 64'(stat_txcount), 64'd0);
        chk("rst_idle", 64'(stat_txidle), 64'd1);
        chk("rst_full", 64'(stat_txfull), 64'd0);
        rst = 1'b1;
        step(2);
        tx_valid = 1'b1;
        tx_data = 8'h55;
        step();
        n = cyc;
        tx_valid = 1'b0;
        chk("single_cnt_n", 64'(stat_txcount), 64'd1);
        chk("single_txd_n", 64'(uart_txd), 64'd1);
        step(40);
        chk("single_busy_n40", 64'(stat_txidle), 64'd0);
        step();
        chk("single_idle_n41", 64'(stat_txidle), 64'd1);
        chk_frame("single_frame_55", n + 1, 8'h55);
        tx_valid = 1'b1;
        tx_data = 8'hA5;
        step();
        n = cyc;
        tx_data = 8'h3C;
        step();
        tx_valid = 1'b0;
        chk("b2b_cnt", 64'(stat_txcount), 64'd1);
        step(80);
        chk("b2b_idle", 64'(stat_txidle), 64'd1);
        chk_frame("b2b_frame_a5", n + 1, 8'hA5);
        chk_frame("b2b_frame_3c", n + 41, 8'h3C);
        n = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            tx_valid = 1'b1;
            tx_data = 8'(i);
            step();
            if (i == 8) begin
                chk("ovf_cnt8", 64'(stat_txcount), 64'd8);
                chk("ovf_ready0", 64'(tx_ready), 64'd0);
                chk("ovf_full", 64'(stat_txfull), 64'd1);
            end
        end
        tx_valid = 1'b0;
        chk("ovf_refused", 64'(stat_txcount), 64'd8);
        step(31);
        chk("fullpop_cnt_before", 64'(stat_txcount), 64'd8);
        chk("fullpop_ready_before", 64'(tx_ready), 64'd0);
        tx_valid = 1'b1;
        tx_data = 8'hEE;
        step();
        tx_valid = 1'b0;
        chk("fullpop_cnt7", 64'(stat_txcount), 64'd7);
        chk("fullpop_ready1", 64'(tx_ready), 64'd1);
        step(320);
        chk("ovf_idle", 64'(stat_txidle), 64'd1);
        chk("ovf_cnt0", 64'(stat_txcount), 64'd0);
        chk("ovf_txd", 64'(uart_txd), 64'd1);
        for (int k = 0; k < 9; k++) chk_frame($sformatf("ovf_frame_%0d", k), n + 1 + 40 * k, 8'(k));
        tx_valid = 1'b1;
        tx_data = 8'h11;
        step();
        m = cyc;
        tx_data = 8'h22;
        step();
        tx_data = 8'h33;
        step();
        tx_valid = 1'b0;
        step(15);
        chk("mid_cnt2", 64'(stat_txcount), 64'd2);
        chk("mid_bit3", 64'(uart_txd), 64'd0);
        rst = 1'b0;
        step();
        chk("mid_rst_txd", 64'(uart_txd), 64'd1);
        chk("mid_rst_cnt", 64'(stat_txcount), 64'd0);
        chk("mid_rst_idle", 64'(stat_txidle), 64'd1);
        chk("mid_rst_ready", 64'(tx_ready), 64'd1);
        rst = 1'b1;
        step(60);
        begin
            logic all_hi;
            all_hi = 1'b1;
            for (int i = m + 18; i < m + 78; i++) all_hi &= txlog[i];
            chk("mid_line_quiet", 64'(all_hi), 64'd1);
        end
        chk("mid_post_idle", 64'(stat_txidle), 64'd1);
        chk("mid_post_cnt", 64'(stat_txcount), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
